collision_scheduler: RTL and testbench

- Sequences one shared collision_detector instance across NUM_OBS obstacle slots once per video frame.
- Each frame_tick starts a scan. Each valid slot's geometry is presented to the detector, and the hit result is sampled one cycle later.
- At scan end the block publishes a per-slot hit mask. It raises a sticky game_over unless a post-start grace window is active.
- Sits between the obstacle generator / game FSM and the combinational collision_detector.

---
 rtl/collision_scheduler_pkg.sv | 24 ++
 rtl/collision_scheduler_if.sv | 27 ++
 rtl/collision_scheduler_obstacle_slot_mux.sv | 43 ++++
 rtl/collision_scheduler.sv | 158 +++++++++++++++
 tb/tb_collision_scheduler.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/collision_scheduler_pkg.sv
// rtl/collision_scheduler_pkg.sv - shared game constants, scheduler state encoding, slot slice helper
package collision_scheduler_pkg;

  localparam int COORD_W     = 10;
  localparam int NUM_OBS_DEF = 4;
  localparam int MAX_OBS     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Buses are zero-extended to MAX_OBS slots so one helper serves every NUM_OBS.
  function automatic logic [COORD_W-1:0] slot_field(
    input logic [COORD_W*MAX_OBS-1:0] bus,
    input int                         slot
  );
    return bus[slot*COORD_W +: COORD_W];
  endfunction

endpackage

// File: rtl/collision_scheduler_if.sv
// rtl/collision_scheduler_if.sv - geometry/hit link between scheduler and collision detector
interface collision_scheduler_if;
  import collision_scheduler_pkg::*;

  logic [COORD_W-1:0] cd_obstacle_x;
  logic [COORD_W-1:0] cd_obstacle_y;
  logic [COORD_W-1:0] cd_obstacle_width;
  logic [COORD_W-1:0] cd_obstacle_height;
  logic               cd_hit;

  modport master (
    output cd_obstacle_x,
    output cd_obstacle_y,
    output cd_obstacle_width,
    output cd_obstacle_height,
    input  cd_hit
  );

  modport slave (
    input  cd_obstacle_x,
    input  cd_obstacle_y,
    input  cd_obstacle_width,
    input  cd_obstacle_height,
    output cd_hit
  );

endinterface

// File: rtl/collision_scheduler_obstacle_slot_mux.sv
// rtl/collision_scheduler_obstacle_slot_mux.sv - combinational pick of one slot from the packed buses
module obstacle_slot_mux
  import collision_scheduler_pkg::*;
#(
  parameter int NUM_OBS = NUM_OBS_DEF,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]           idx,
  input  logic [NUM_OBS-1:0]         obs_valid,
  input  logic [COORD_W*NUM_OBS-1:0] obs_x_bus,
  input  logic [COORD_W*NUM_OBS-1:0] obs_y_bus,
  input  logic [COORD_W*NUM_OBS-1:0] obs_w_bus,
  input  logic [COORD_W*NUM_OBS-1:0] obs_h_bus,
  output logic [COORD_W-1:0]         slot_x,
  output logic [COORD_W-1:0]         slot_y,
  output logic [COORD_W-1:0]         slot_w,
  output logic [COORD_W-1:0]         slot_h,
  output logic                       slot_valid
);

  logic [COORD_W*MAX_OBS-1:0] x_ext;
  logic [COORD_W*MAX_OBS-1:0] y_ext;
  logic [COORD_W*MAX_OBS-1:0] w_ext;
  logic [COORD_W*MAX_OBS-1:0] h_ext;

  always_comb begin
    x_ext = '0;
    y_ext = '0;
    w_ext = '0;
    h_ext = '0;
    x_ext[COORD_W*NUM_OBS-1:0] = obs_x_bus;
    y_ext[COORD_W*NUM_OBS-1:0] = obs_y_bus;
    w_ext[COORD_W*NUM_OBS-1:0] = obs_w_bus;
    h_ext[COORD_W*NUM_OBS-1:0] = obs_h_bus;
  end

  assign slot_x     = slot_field(x_ext, int'(idx));
  assign slot_y     = slot_field(y_ext, int'(idx));
  assign slot_w     = slot_field(w_ext, int'(idx));
  assign slot_h     = slot_field(h_ext, int'(idx));
  assign slot_valid = obs_valid[idx];

endmodule

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - time-shares one collision detector over all obstacle slots each frame
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int NUM_OBS      = NUM_OBS_DEF,
  parameter int IDX_W        = 2,
  parameter int GRACE_FRAMES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       frame_tick,
  input  logic                       clear,
  input  logic [NUM_OBS-1:0]         obs_valid,
  input  logic [COORD_W*NUM_OBS-1:0] obs_x_bus,
  input  logic [COORD_W*NUM_OBS-1:0] obs_y_bus,
  input  logic [COORD_W*NUM_OBS-1:0] obs_w_bus,
  input  logic [COORD_W*NUM_OBS-1:0] obs_h_bus,
  collision_scheduler_if.master      cd,
  output logic [NUM_OBS-1:0]         hit_mask,
  output logic                       scan_done,
  output logic                       busy,
  output logic                       game_over,
  output logic                       overrun
);

  localparam int                GRACE_W    = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);
  localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_FRAMES);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_OBS - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [NUM_OBS-1:0]   shadow;
  logic [GRACE_W-1:0]   grace_cnt;
  logic                 enable_q;
  logic [COORD_W-1:0]   cd_x_q, cd_y_q, cd_w_q, cd_h_q;

  logic [COORD_W-1:0]   slot_x, slot_y, slot_w, slot_h;
  logic                 slot_valid;
  logic                 scanning;

  obstacle_slot_mux #(
    .NUM_OBS (NUM_OBS),
    .IDX_W   (IDX_W)
  ) u_slot_mux (
    .idx        (idx),
    .obs_valid  (obs_valid),
    .obs_x_bus  (obs_x_bus),
    .obs_y_bus  (obs_y_bus),
    .obs_w_bus  (obs_w_bus),
    .obs_h_bus  (obs_h_bus),
    .slot_x     (slot_x),
    .slot_y     (slot_y),
    .slot_w     (slot_w),
    .slot_h     (slot_h),
    .slot_valid (slot_valid)
  );

  assign scanning = (state == ST_LOAD) || (state == ST_SAMPLE) || (state == ST_DONE);

  // Detector inputs only move in LOAD, so the detector gets the whole SAMPLE cycle to settle.
  assign cd.cd_obstacle_x      = cd_x_q;
  assign cd.cd_obstacle_y      = cd_y_q;
  assign cd.cd_obstacle_width  = cd_w_q;
  assign cd.cd_obstacle_height = cd_h_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      shadow    <= '0;
      grace_cnt <= GRACE_INIT;
      enable_q  <= 1'b0;
      cd_x_q    <= '0;
      cd_y_q    <= '0;
      cd_w_q    <= '0;
      cd_h_q    <= '0;
      hit_mask  <= '0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      enable_q  <= enable;
      scan_done <= 1'b0;

      if (clear) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        game_over <= 1'b0;
        overrun   <= 1'b0;
        grace_cnt <= GRACE_INIT;
      end else begin
        if (frame_tick && scanning) begin
          overrun <= 1'b1;
        end
        if (enable && !enable_q) begin
          grace_cnt <= GRACE_INIT;
        end

        if (scanning && !enable) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (frame_tick && enable) begin
                state  <= ST_LOAD;
                idx    <= '0;
                shadow <= '0;
                busy   <= 1'b1;
              end
            end
            ST_LOAD: begin
              cd_x_q <= slot_x;
              cd_y_q <= slot_y;
              cd_w_q <= slot_w;
              cd_h_q <= slot_h;
              state  <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
              // Empty slots are still visited so every scan takes the same time.
              shadow[idx] <= cd.cd_hit & slot_valid;
              if (idx == LAST_IDX) begin
                state <= ST_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= ST_LOAD;
              end
            end
            ST_DONE: begin
              hit_mask  <= shadow;
              scan_done <= 1'b1;
              busy      <= 1'b0;
              if (grace_cnt != '0) begin
                grace_cnt <= grace_cnt - 1'b1;
                state     <= ST_IDLE;
              end else if (|shadow) begin
                game_over <= 1'b1;
                state     <= ST_OVER;
              end else begin
                state <= ST_IDLE;
              end
            end
            ST_OVER: begin
              state <= ST_OVER;
            end
            default: begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - directed bench for collision_scheduler with grace 0 and grace 2 instances
module tb_collision_scheduler;
  import collision_scheduler_pkg::*;

  localparam int N        = 4;
  localparam int PLAYER_X = 100;
  localparam int PLAYER_Y = 315;
  localparam int PLAYER_W = 20;
  localparam int PLAYER_H = 30;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            frame_tick;
  logic            clear;
  logic [N-1:0]    obs_valid;
  logic [10*N-1:0] obs_x_bus, obs_y_bus, obs_w_bus, obs_h_bus;

  logic [N-1:0] hm0, hm2;
  logic         sd0, sd2, busy0, busy2, go0, go2, ov0, ov2;

  int n_checks;
  int n_errs;
  int lat, nd0, nd2;

  collision_scheduler_if cd0();
  collision_scheduler_if cd2();

  function automatic logic detect(input logic [9:0] ox, input logic [9:0] oy,
                                  input logic [9:0] ow, input logic [9:0] oh);
    int x, y, w, h;
    x = int'(ox); y = int'(oy); w = int'(ow); h = int'(oh);
    return (x < PLAYER_X + PLAYER_W) && (PLAYER_X < x + w) &&
           (y < PLAYER_Y + PLAYER_H) && (PLAYER_Y < y + h);
  endfunction

  assign cd0.cd_hit = detect(cd0.cd_obstacle_x, cd0.cd_obstacle_y, cd0.cd_obstacle_width, cd0.cd_obstacle_height);
  assign cd2.cd_hit = detect(cd2.cd_obstacle_x, cd2.cd_obstacle_y, cd2.cd_obstacle_width, cd2.cd_obstacle_height);

  collision_scheduler #(.NUM_OBS(N), .IDX_W(2), .GRACE_FRAMES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick), .clear(clear),
    .obs_valid(obs_valid), .obs_x_bus(obs_x_bus), .obs_y_bus(obs_y_bus),
    .obs_w_bus(obs_w_bus), .obs_h_bus(obs_h_bus), .cd(cd0),
    .hit_mask(hm0), .scan_done(sd0), .busy(busy0), .game_over(go0), .overrun(ov0)
  );

  collision_scheduler #(.NUM_OBS(N), .IDX_W(2), .GRACE_FRAMES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick), .clear(clear),
    .obs_valid(obs_valid), .obs_x_bus(obs_x_bus), .obs_y_bus(obs_y_bus),
    .obs_w_bus(obs_w_bus), .obs_h_bus(obs_h_bus), .cd(cd2),
    .hit_mask(hm2), .scan_done(sd2), .busy(busy2), .game_over(go2), .overrun(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  // Tick, then watch 20 cycles: latency of first dut2 scan_done and pulse counts of both.
  task automatic run_scan(input int second_at, output int lat_o, output int n0, output int n2);
    lat_o = -1; n0 = 0; n2 = 0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (sd2) begin
        n2++;
        if (lat_o < 0) lat_o = k;
      end
      if (sd0) n0++;
      frame_tick = (k == second_at);
    end
  endtask

  initial begin
    n_checks = 0; n_errs = 0;
    rst_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; clear = 1'b0;
    obs_valid = 4'b1110;
    obs_x_bus = {10'd400, 10'd400, 10'd400, 10'd110};
    obs_y_bus = {10'd300, 10'd300, 10'd300, 10'd300};
    obs_w_bus = {10'd20,  10'd20,  10'd20,  10'd20};
    obs_h_bus = {10'd20,  10'd20,  10'd20,  10'd20};

    #12;
    check("rst_hit_mask", 32'(hm2), 32'h0);
    check("rst_busy", 32'(busy2), 32'h0);
    check("rst_game_over", 32'(go0), 32'h0);
    check("rst_cd_x", 32'(cd2.cd_obstacle_x), 32'h0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1 enable = 1'b1;

    // slot0 invalid: no hits anywhere
    run_scan(0, lat, nd0, nd2);
    check("inv_latency", 32'(lat), 32'd9);
    check("inv_hm0", 32'(hm0), 32'h0);
    check("inv_go0", 32'(go0), 32'h0);
    check("inv_hm2", 32'(hm2), 32'h0);
    pulse_clear();

    // slot0 hits: grace 0 ends the game, grace 2 absorbs it
    obs_valid = 4'b1111;
    run_scan(0, lat, nd0, nd2);
    check("hit_latency", 32'(lat), 32'd9);
    check("hit_hm0", 32'(hm0), 32'h1);
    check("hit_go0", 32'(go0), 32'h1);
    check("hit_hm2", 32'(hm2), 32'h1);
    check("grace1_go2", 32'(go2), 32'h0);

    run_scan(0, lat, nd0, nd2);
    check("over_ignores_tick", 32'(nd0), 32'd0);
    check("over_hm0_held", 32'(hm0), 32'h1);
    check("grace2_done", 32'(nd2), 32'd1);
    check("grace2_go2", 32'(go2), 32'h0);

    run_scan(0, lat, nd0, nd2);
    check("grace_exp_go2", 32'(go2), 32'h1);
    check("grace_exp_hm2", 32'(hm2), 32'h1);
    pulse_clear();
    check("clear_go0", 32'(go0), 32'h0);
    check("clear_go2", 32'(go2), 32'h0);

    // second tick while busy is dropped
    run_scan(3, lat, nd0, nd2);
    check("ovr_one_done", 32'(nd2), 32'd1);
    check("ovr_flag2", 32'(ov2), 32'h1);
    check("ovr_flag0", 32'(ov0), 32'h1);
    pulse_clear();
    check("ovr_clear2", 32'(ov2), 32'h0);
    check("ovr_clear_go0", 32'(go0), 32'h0);

    // enable dropped mid-scan
    obs_valid = 4'b1110;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("en_busy_before", 32'(busy2), 32'h1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("en_busy2_after", 32'(busy2), 32'h0);
    check("en_busy0_after", 32'(busy0), 32'h0);
    nd2 = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (sd2) nd2++;
    end
    check("en_no_done", 32'(nd2), 32'd0);
    check("en_hm2_held", 32'(hm2), 32'h1);
    enable = 1'b1;

    // asynchronous reset mid-scan
    obs_valid = 4'b1111;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #4 check("mid_cd_x", 32'(cd2.cd_obstacle_x), 32'd400);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy2), 32'h0);
    check("arst_cd_x", 32'(cd2.cd_obstacle_x), 32'h0);
    check("arst_hm0", 32'(hm0), 32'h0);
    #2 rst_n = 1'b1;
    run_scan(0, lat, nd0, nd2);
    check("post_rst_latency", 32'(lat), 32'd9);
    check("post_rst_hm2", 32'(hm2), 32'h1);
    check("post_rst_go0", 32'(go0), 32'h1);
    check("post_rst_go2", 32'(go2), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
